// File: rtl/ssram_write_buffer_if.sv
// ssram_write_buffer_if
//   Bundles the two request paths around the serial SRAM write buffer.
//   Bus side (CPU / cartridge decoder):
//     bus_address[18:0], bus_valid, bus_write, bus_wdata[7:0]  -> buffer
//     bus_ready, bus_rdata[7:0], bus_rdata_en                  <- buffer
//   Memory side (SRAM controller valid/ready byte port):
//     mem_address[18:0], mem_valid, mem_write, mem_wdata[7:0]  <- buffer
//     mem_ready, mem_rdata[7:0]                                -> buffer
//   Modports:
//     slave  - the write buffer itself
//     master - the environment (bus decoder plus SRAM controller)
interface ssram_write_buffer_if;
  logic [18:0] bus_address;
  logic        bus_valid;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic        bus_ready;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;

  logic [18:0] mem_address;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  bus_address, bus_valid, bus_write, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en,
    output mem_address, mem_valid, mem_write, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output bus_address, bus_valid, bus_write, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en,
    input  mem_address, mem_valid, mem_write, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ssram_write_buffer.sv
// ssram_write_buffer
//   Request-side front end for the serial SRAM controller. Byte writes from
//   the CPU are posted into a small circular FIFO so the CPU never waits on
//   the serial write sequence. Reads are forwarded from the newest queued
//   write to the same address when possible; otherwise the FIFO is drained
//   and a single downstream read is issued, keeping memory ordering intact.
//
//   Ports:
//     clk    - system clock, the only clock
//     reset  - synchronous, active-high reset
//     bif    - ssram_write_buffer_if.slave: bus request port and SRAM
//              controller valid/ready port (see interface header)
//
//   Parameters:
//     DEPTH_LOG2 - log2 of the write FIFO depth (1..3)
module ssram_write_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ssram_write_buffer_if.slave   bif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  // FIFO storage and bookkeeping
  logic [18:0]           fifo_addr_q [DEPTH];
  logic [18:0]           fifo_addr_d [DEPTH];
  logic [7:0]            fifo_data_q [DEPTH];
  logic [7:0]            fifo_data_d [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  // Pending downstream read
  logic                  rd_pend_q, rd_pend_d;
  logic [18:0]           rd_addr_q, rd_addr_d;

  state_e                state_q, state_d;

  // Registered outputs
  logic                  bus_ready_q, bus_ready_d;
  logic [7:0]            bus_rdata_q, bus_rdata_d;
  logic                  bus_rdata_en_q, bus_rdata_en_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_write_q, mem_write_d;
  logic [18:0]           mem_address_q, mem_address_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;

  logic                  push;
  logic                  rd_accept;
  logic                  pop;
  logic                  fwd_hit;
  logic [7:0]            fwd_data;
  logic [DEPTH_LOG2-1:0] fwd_idx;

  // A request is only seen while bus_ready is high; anything else is dropped.
  assign push      = bif.bus_valid & bus_ready_q &  bif.bus_write;
  assign rd_accept = bif.bus_valid & bus_ready_q & ~bif.bus_write;

  // Store-to-load forwarding. Walk the occupied slots oldest to newest so
  // the last match is the newest write. Slots beyond count hold stale data
  // from earlier pops and must never match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    fwd_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + DEPTH_LOG2'(i);
      if (((DEPTH_LOG2 + 1)'(i) < count_q) &&
          (fifo_addr_q[fwd_idx] == bif.bus_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data_q[fwd_idx];
      end
    end
  end

  // Next-state logic: FIFO, read tracking and downstream FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    rd_pend_d      = rd_pend_q;
    rd_addr_d      = rd_addr_q;
    fifo_addr_d    = fifo_addr_q;
    fifo_data_d    = fifo_data_q;
    bus_rdata_d    = bus_rdata_q;
    bus_rdata_en_d = 1'b0;
    mem_valid_d    = mem_valid_q;
    mem_write_d    = mem_write_q;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    pop            = 1'b0;

    if (push) begin
      fifo_addr_d[tail_q] = bif.bus_address;
      fifo_data_d[tail_q] = bif.bus_wdata;
      tail_d              = tail_q + DEPTH_LOG2'(1);
    end

    if (rd_accept) begin
      if (fwd_hit) begin
        bus_rdata_d    = fwd_data;
        bus_rdata_en_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = bif.bus_address;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // Queued writes always go first so a pending read observes them.
        if ((count_q != '0) && bif.mem_ready) begin
          mem_address_d = fifo_addr_q[head_q];
          mem_wdata_d   = fifo_data_q[head_q];
          mem_write_d   = 1'b1;
          mem_valid_d   = 1'b1;
          state_d       = ST_REQ;
        end else if (rd_pend_q && (count_q == '0) && bif.mem_ready) begin
          mem_address_d = rd_addr_q;
          mem_write_d   = 1'b0;
          mem_valid_d   = 1'b1;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        // The controller signals acceptance by dropping ready.
        if (!bif.mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // mem_write still records which kind of access is finishing.
        if (bif.mem_ready) begin
          state_d = ST_IDLE;
          if (mem_write_q) begin
            pop = 1'b1;
          end else begin
            bus_rdata_d    = bif.mem_rdata;
            bus_rdata_en_d = 1'b1;
            rd_pend_d      = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      head_d = head_q + DEPTH_LOG2'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase

    // Registered ready reflects the state after this edge, so a fill or a
    // read miss blocks the very next request.
    bus_ready_d = (count_d < FULL_COUNT) && !rd_pend_d;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= ST_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rd_pend_q      <= 1'b0;
      rd_addr_q      <= '0;
      bus_ready_q    <= 1'b0;
      bus_rdata_q    <= 8'h00;
      bus_rdata_en_q <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_wdata_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rd_pend_q      <= rd_pend_d;
      rd_addr_q      <= rd_addr_d;
      bus_ready_q    <= bus_ready_d;
      bus_rdata_q    <= bus_rdata_d;
      bus_rdata_en_q <= bus_rdata_en_d;
      mem_valid_q    <= mem_valid_d;
      mem_write_q    <= mem_write_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is defined by count, so
  // leftover contents are never forwarded or drained.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bif.bus_ready    = bus_ready_q;
  assign bif.bus_rdata    = bus_rdata_q;
  assign bif.bus_rdata_en = bus_rdata_en_q;
  assign bif.mem_valid    = mem_valid_q;
  assign bif.mem_write    = mem_write_q;
  assign bif.mem_address  = mem_address_q;
  assign bif.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_ssram_write_buffer.sv
// tb_ssram_write_buffer
//   Directed bench for ssram_write_buffer. A behavioural SRAM controller
//   (ready low for 10 cycles per access) services downstream requests.
//   Expected downstream accesses and expected read returns are queued when
//   stimulus is driven and compared when the DUT produces them.
module tb_ssram_write_buffer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ssram_write_buffer_if bif ();

  ssram_write_buffer #(.DEPTH_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  data;
  } mem_txn_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_txn_t;

  mem_txn_t   mem_exp_q[$];
  rd_txn_t    rd_exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         model_en   = 1'b0;
  bit         model_busy = 1'b0;
  logic [7:0] model_rdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bif.bus_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("bus_ready_wait", {31'd0, bif.bus_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [18:0] addr, input logic [7:0] data, input bit drains);
    wait_ready();
    bif.bus_valid   = 1'b1;
    bif.bus_write   = 1'b1;
    bif.bus_address = addr;
    bif.bus_wdata   = data;
    if (drains) mem_exp_q.push_back('{1'b1, addr, data});
    tick();
    bif.bus_valid = 1'b0;
  endtask

  task automatic do_read(input logic [18:0] addr, input bit hit, input logic [7:0] data);
    wait_ready();
    bif.bus_valid   = 1'b1;
    bif.bus_write   = 1'b0;
    bif.bus_address = addr;
    if (hit) begin
      rd_exp_q.push_back('{data, cyc + 1});
    end else begin
      mem_exp_q.push_back('{1'b0, addr, 8'h00});
      rd_exp_q.push_back('{data, -1});
    end
    tick();
    bif.bus_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((mem_exp_q.size() != 0 || rd_exp_q.size() != 0 || model_busy) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (n < 3000)}, 32'd1);
    tick();
    tick();
  endtask

  // SRAM controller model: accepts a request by dropping ready one cycle
  // after it appears (so hold is observable), stays busy 10 cycles.
  initial begin : mem_model
    mem_txn_t    e;
    logic [18:0] a;
    logic [7:0]  d;
    logic        w;
    forever begin
      tick();
      if (model_en) begin
        if (!model_busy) bif.mem_ready = 1'b1;
        if (bif.mem_valid === 1'b1 && bif.mem_ready === 1'b1) begin
          model_busy = 1'b1;
          a = bif.mem_address;
          d = bif.mem_wdata;
          w = bif.mem_write;
          if (mem_exp_q.size() == 0) begin
            check("unexpected_mem_req", {13'd0, a}, 32'h7ffff_fff);
          end else begin
            e = mem_exp_q.pop_front();
            check("mem_write", {31'd0, w}, {31'd0, e.wr});
            check("mem_address", {13'd0, a}, {13'd0, e.addr});
            if (e.wr) check("mem_wdata", {24'd0, d}, {24'd0, e.data});
          end
          tick();
          check("mem_hold_valid", {31'd0, bif.mem_valid}, 32'd1);
          check("mem_hold_addr", {13'd0, bif.mem_address}, {13'd0, a});
          check("mem_hold_wdata", {24'd0, bif.mem_wdata}, {24'd0, d});
          bif.mem_ready = 1'b0;
          tick();
          check("mem_valid_drop", {31'd0, bif.mem_valid}, 32'd0);
          repeat (9) tick();
          if (!w) bif.mem_rdata = model_rdata;
          bif.mem_ready = 1'b1;
          model_busy    = 1'b0;
        end
      end
    end
  end

  // Read-return monitor.
  initial begin : rd_monitor
    rd_txn_t r;
    forever begin
      tick();
      if (bif.bus_rdata_en === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          check("unexpected_rdata_en", {24'd0, bif.bus_rdata}, 32'hffff_ffff);
        end else begin
          r = rd_exp_q.pop_front();
          check("bus_rdata", {24'd0, bif.bus_rdata}, {24'd0, r.data});
          if (r.cyc >= 0) check("rdata_latency", cyc, r.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n;
    bit          bad;
    logic [18:0] a;
    logic [7:0]  d;

    reset           = 1'b1;
    bif.bus_valid   = 1'b0;
    bif.bus_write   = 1'b0;
    bif.bus_address = '0;
    bif.bus_wdata   = 8'h00;
    bif.mem_ready   = 1'b0;
    bif.mem_rdata   = 8'h00;

    // 1: reset values, then fill with mem_ready low
    repeat (3) tick();
    check("rst_bus_ready", {31'd0, bif.bus_ready}, 32'd0);
    check("rst_bus_rdata", {24'd0, bif.bus_rdata}, 32'd0);
    check("rst_bus_rdata_en", {31'd0, bif.bus_rdata_en}, 32'd0);
    check("rst_mem_valid", {31'd0, bif.mem_valid}, 32'd0);
    check("rst_mem_write", {31'd0, bif.mem_write}, 32'd0);
    check("rst_mem_address", {13'd0, bif.mem_address}, 32'd0);
    check("rst_mem_wdata", {24'd0, bif.mem_wdata}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, bif.bus_ready}, 32'd1);
    do_write(19'h00010, 8'hA5, 1'b1);
    do_write(19'h00011, 8'h5A, 1'b1);
    do_write(19'h7FFFF, 8'h3C, 1'b1);
    do_write(19'h00000, 8'hFF, 1'b1);
    check("full_ready_low", {31'd0, bif.bus_ready}, 32'd0);
    check("full_no_mem_valid", {31'd0, bif.mem_valid}, 32'd0);
    repeat (5) tick();
    check("full_still_idle", {31'd0, bif.mem_valid}, 32'd0);

    // 2: release the controller and drain four writes in order
    model_en = 1'b1;
    n = 0;
    while (bif.bus_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("ready_after_first_pop", {31'd0, bif.bus_ready}, 32'd1);
    check("count_after_first_pop", {29'd0, dut.count_q}, 32'd3);
    wait_drain("drain_s2");
    check("count_empty_s2", {29'd0, dut.count_q}, 32'd0);

    // Popped slot must not forward stale data: expect a downstream read
    model_rdata = 8'h4E;
    do_read(19'h00010, 1'b0, 8'h4E);
    wait_drain("drain_stale");

    // 3: forwarding, newest match wins, no downstream read
    model_en      = 1'b0;
    bif.mem_ready = 1'b0;
    do_write(19'h00100, 8'h11, 1'b1);
    do_write(19'h00100, 8'h22, 1'b1);
    do_read(19'h00100, 1'b1, 8'h22);
    tick();
    check("fwd_delivered", rd_exp_q.size(), 32'd0);
    model_en = 1'b1;
    wait_drain("drain_s3");

    // 4: read miss behind a queued write
    model_rdata = 8'h9C;
    do_write(19'h00200, 8'h77, 1'b1);
    do_read(19'h12345, 1'b0, 8'h9C);
    n   = 0;
    bad = 1'b0;
    while (bif.bus_rdata_en !== 1'b1 && n < 500) begin
      if (bif.bus_ready !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    check("ready_low_while_pending", {31'd0, bad}, 32'd0);
    check("miss_read_returned", {31'd0, bif.bus_rdata_en}, 32'd1);
    wait_drain("drain_s4");

    // 5: twelve writes through a depth-4 FIFO, pointers wrap three times
    for (int i = 0; i < 12; i++) begin
      a = 19'h40000 + 19'(i * 273);
      d = 8'(i * 19 + 7);
      do_write(a, d, 1'b1);
    end
    wait_drain("drain_s5");
    check("count_empty_s5", {29'd0, dut.count_q}, 32'd0);

    // 6: reset while a write is in REQ with two entries queued
    model_en      = 1'b0;
    bif.mem_ready = 1'b0;
    do_write(19'h00AAA, 8'hDE, 1'b0);
    do_write(19'h00BBB, 8'hAD, 1'b0);
    bif.mem_ready = 1'b1;
    n = 0;
    while (bif.mem_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("s6_in_req", {31'd0, bif.mem_valid}, 32'd1);
    reset = 1'b1;
    tick();
    check("s6_mem_valid", {31'd0, bif.mem_valid}, 32'd0);
    check("s6_count", {29'd0, dut.count_q}, 32'd0);
    check("s6_bus_ready", {31'd0, bif.bus_ready}, 32'd0);
    reset = 1'b0;
    model_en = 1'b1;
    repeat (20) tick();
    check("s6_no_stale_req", {31'd0, bif.mem_valid}, 32'd0);
    do_write(19'h00055, 8'h66, 1'b1);
    wait_drain("drain_s6");

    check("sb_mem_empty", mem_exp_q.size(), 32'd0);
    check("sb_rd_empty", rd_exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
